// File: rtl/glb_stage_fifo.sv
// Elastic GLB staging buffer: circular register array with valid/ready on both sides.
// Latency: a word pushed at posedge N is on rd_data/rd_valid right after posedge N (no empty bypass).
// Backpressure: wr_ready = !full and rd_valid = !empty, both decoded from the registered count only.
module glb_stage_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full
);

  // Pointer width indexes DEPTH entries; count width must also represent DEPTH itself.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);

  // Storage and bookkeeping state.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  // Flags decoded purely from the registered count.
  logic w_full;
  logic w_empty;
  logic w_almost_full;

  // Qualified transfers for this cycle.
  logic w_push;
  logic w_pop;

  // Next pointer values with explicit wrap (DEPTH need not be a power of two).
  logic [PW-1:0] w_wr_ptr_inc;
  logic [PW-1:0] w_rd_ptr_inc;

  // Registered-state flag decode; no input reaches these.
  always_comb begin
    w_full        = (r_count == DEPTH_C);
    w_empty       = (r_count == '0);
    w_almost_full = (r_count >= AF_C);
  end

  // Handshake qualification: push gated by !full, pop gated by !empty, both registered.
  always_comb begin
    w_push = wr_valid & ~w_full;
    w_pop  = rd_ready & ~w_empty;
  end

  // Wrap-aware pointer increments.
  always_comb begin
    w_wr_ptr_inc = (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + PW'(1);
    w_rd_ptr_inc = (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + PW'(1);
  end

  // Pointer and occupancy update; reset beats clear, clear beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Array write; contents need no reset since empty masks rd_data and pointers restart at 0.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Output drive: oldest entry, forced to zero while empty so the downstream flop sees a clean value.
  always_comb begin
    rd_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    rd_valid    = ~w_empty;
    wr_ready    = ~w_full;
    count       = r_count;
    full        = w_full;
    empty       = w_empty;
    almost_full = w_almost_full;
  end

endmodule
